// File: rtl/morse_decoder.sv
// morse_decoder: turns dot/dash pulses into ASCII characters, closing a character
// after CHAR_GAP idle cycles and emitting one space after WORD_GAP idle cycles.
module morse_decoder #(
    parameter logic [27:0] CHAR_GAP = 28'd50_000_000,
    parameter logic [27:0] WORD_GAP = 28'd150_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SHORT,
    input  logic       LONG,
    output logic [7:0] CHAR,
    output logic       CHAR_VALID,
    output logic       ERR,
    output logic [2:0] SYM_CNT,
    output logic       BUSY
);
    typedef enum logic [2:0] {IDLE, COLLECT, ERRWAIT, EMIT, SPACEWAIT} state_t;

    state_t      state, state_n;
    logic [4:0]  code, code_n;
    logic [27:0] gap, gap_n;
    logic [2:0]  cnt_n;
    logic [7:0]  char_n;
    logic        valid_n, err_n, sym, both, char_hit, word_hit;

    // first symbol sits in the highest used bit; upper unused bits are zero
    function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] c);
        case ({n, c})
            {3'd1, 5'b00000}: decode = 8'h45;
            {3'd1, 5'b00001}: decode = 8'h54;
            {3'd2, 5'b00000}: decode = 8'h49;
            {3'd2, 5'b00001}: decode = 8'h41;
            {3'd2, 5'b00010}: decode = 8'h4E;
            {3'd2, 5'b00011}: decode = 8'h4D;
            {3'd3, 5'b00000}: decode = 8'h53;
            {3'd3, 5'b00001}: decode = 8'h55;
            {3'd3, 5'b00010}: decode = 8'h52;
            {3'd3, 5'b00011}: decode = 8'h57;
            {3'd3, 5'b00100}: decode = 8'h44;
            {3'd3, 5'b00101}: decode = 8'h4B;
            {3'd3, 5'b00110}: decode = 8'h47;
            {3'd3, 5'b00111}: decode = 8'h4F;
            {3'd4, 5'b00000}: decode = 8'h48;
            {3'd4, 5'b00001}: decode = 8'h56;
            {3'd4, 5'b00010}: decode = 8'h46;
            {3'd4, 5'b00100}: decode = 8'h4C;
            {3'd4, 5'b00110}: decode = 8'h50;
            {3'd4, 5'b00111}: decode = 8'h4A;
            {3'd4, 5'b01000}: decode = 8'h42;
            {3'd4, 5'b01001}: decode = 8'h58;
            {3'd4, 5'b01010}: decode = 8'h43;
            {3'd4, 5'b01011}: decode = 8'h59;
            {3'd4, 5'b01100}: decode = 8'h5A;
            {3'd4, 5'b01101}: decode = 8'h51;
            {3'd5, 5'b11111}: decode = 8'h30;
            {3'd5, 5'b01111}: decode = 8'h31;
            {3'd5, 5'b00111}: decode = 8'h32;
            {3'd5, 5'b00011}: decode = 8'h33;
            {3'd5, 5'b00001}: decode = 8'h34;
            {3'd5, 5'b00000}: decode = 8'h35;
            {3'd5, 5'b10000}: decode = 8'h36;
            {3'd5, 5'b11000}: decode = 8'h37;
            {3'd5, 5'b11100}: decode = 8'h38;
            {3'd5, 5'b11110}: decode = 8'h39;
            default:          decode = 8'h3F;
        endcase
    endfunction

    always_comb begin
        sym      = SHORT ^ LONG;
        both     = SHORT & LONG;
        char_hit = !(SHORT | LONG) && gap == CHAR_GAP - 28'd1;
        word_hit = !(SHORT | LONG) && gap == WORD_GAP - 28'd1;
        state_n  = state;
        code_n   = code;
        cnt_n    = SYM_CNT;
        char_n   = CHAR;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        gap_n    = (SHORT | LONG) ? 28'd0 : (gap == WORD_GAP ? gap : gap + 28'd1);
        if (both) begin
            state_n = ERRWAIT;
        end else begin
            case (state)
                COLLECT: begin
                    if (sym && SYM_CNT == 3'd5) begin
                        state_n = ERRWAIT;
                    end else if (sym) begin
                        code_n = {code[3:0], LONG};
                        cnt_n  = SYM_CNT + 3'd1;
                    end else if (char_hit) begin
                        state_n = EMIT;
                        char_n  = decode(SYM_CNT, code);
                        err_n   = char_n == 8'h3F;
                        valid_n = 1'b1;
                    end
                end
                ERRWAIT: begin
                    if (char_hit) begin
                        state_n = EMIT;
                        char_n  = 8'h3F;
                        err_n   = 1'b1;
                        valid_n = 1'b1;
                    end
                end
                default: begin
                    cnt_n = state == EMIT ? 3'd0 : SYM_CNT;
                    if (sym) begin
                        state_n = COLLECT;
                        code_n  = {4'b0, LONG};
                        cnt_n   = 3'd1;
                    end else if (state != IDLE && word_hit) begin
                        state_n = IDLE;
                        char_n  = 8'h20;
                        valid_n = 1'b1;
                    end else if (state == EMIT) begin
                        state_n = SPACEWAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            code       <= 5'd0;
            gap        <= 28'd0;
            SYM_CNT    <= 3'd0;
            CHAR       <= 8'h00;
            CHAR_VALID <= 1'b0;
            ERR        <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            code       <= code_n;
            gap        <= gap_n;
            SYM_CNT    <= cnt_n;
            CHAR       <= char_n;
            CHAR_VALID <= valid_n;
            ERR        <= err_n;
            BUSY       <= state_n == COLLECT || state_n == ERRWAIT;
        end
    end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed stimulus pushes expected strobes into a queue;
// an independent monitor pops and compares each CHAR_VALID strobe.
module tb_morse_decoder;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       SHORT = 1'b0;
    logic       LONG = 1'b0;
    logic [7:0] CHAR;
    logic       CHAR_VALID, ERR, BUSY;
    logic [2:0] SYM_CNT;

    typedef struct {
        logic [7:0] ch;
        logic       e;
        int         at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last = 0;
    int   checks = 0;
    int   fails = 0;

    morse_decoder #(.CHAR_GAP(28'd16), .WORD_GAP(28'd48)) dut (
        .CLK(CLK), .RESET(RESET), .SHORT(SHORT), .LONG(LONG), .CHAR(CHAR),
        .CHAR_VALID(CHAR_VALID), .ERR(ERR), .SYM_CNT(SYM_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] ch, input logic e, input int at);
        exp_t x;
        x.ch = ch;
        x.e  = e;
        x.at = at;
        q.push_back(x);
    endtask

    // drives a one-cycle pulse; last = cycle index of the edge that samples it
    task automatic pulse(input logic s, input logic l);
        SHORT = s;
        LONG  = l;
        @(posedge CLK);
        #1;
        SHORT = 1'b0;
        LONG  = 1'b0;
        last  = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (CHAR_VALID) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {24'd0, CHAR}, 32'hFFFF);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("char", {24'd0, CHAR}, {24'd0, x.ch});
                chk("err", {31'd0, ERR}, {31'd0, x.e});
                chk("strobe_cycle", cyc, x.at);
            end
        end
    end

    int          n_tab[4] = '{5, 4, 4, 4};
    logic [4:0]  c_tab[4] = '{5'b11111, 5'b01101, 5'b00000, 5'b00101};
    logic [7:0]  ch_tab[4] = '{8'h30, 8'h51, 8'h48, 8'h3F};

    initial begin
        logic [4:0] c;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_char", {24'd0, CHAR}, 0);
        chk("rst_valid", {31'd0, CHAR_VALID}, 0);
        chk("rst_err", {31'd0, ERR}, 0);
        chk("rst_symcnt", {29'd0, SYM_CNT}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        RESET = 1'b1;
        idle(2);

        pulse(1, 0);
        idle(3);
        pulse(0, 1);
        chk("a_symcnt", {29'd0, SYM_CNT}, 2);
        chk("a_busy", {31'd0, BUSY}, 1);
        push(8'h41, 0, last + 16);
        push(8'h20, 0, last + 48);
        idle(220);
        chk("a_symcnt_after", {29'd0, SYM_CNT}, 0);
        chk("a_busy_after", {31'd0, BUSY}, 0);

        for (int i = 0; i < 6; i++) begin
            pulse(1, 0);
            if (i < 5) idle(2);
        end
        push(8'h3F, 1, last + 16);
        push(8'h20, 0, last + 48);
        idle(60);

        pulse(1, 0);
        idle(15);
        pulse(0, 1);
        push(8'h41, 0, last + 16);
        push(8'h20, 0, last + 48);
        idle(60);

        pulse(0, 1);
        idle(2);
        pulse(0, 1);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        chk("midreset_symcnt", {29'd0, SYM_CNT}, 0);
        pulse(1, 0);
        push(8'h45, 0, last + 16);
        push(8'h20, 0, last + 48);
        idle(60);

        pulse(1, 1);
        chk("both_busy", {31'd0, BUSY}, 1);
        push(8'h3F, 1, last + 16);
        push(8'h20, 0, last + 48);
        idle(60);

        for (int k = 0; k < 4; k++) begin
            c = c_tab[k];
            for (int j = n_tab[k] - 1; j >= 0; j--) begin
                pulse(!c[j], c[j]);
                if (j > 0) idle(2);
            end
            chk("tab_symcnt", {29'd0, SYM_CNT}, n_tab[k]);
            push(ch_tab[k], ch_tab[k] == 8'h3F, last + 16);
            idle(20);
        end
        push(8'h20, 0, last + 48);

        for (int t = 0; t < 300 && q.size() != 0; t++) idle(1);
        idle(100);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
